vec_inst_queue: RTL and testbench
=================================

Name: vec_inst_queue

Overview:
- Decoupling FIFO between the scalar core's issue stage and the vector processor controller/decode stage.
- Accepts vector instructions with their scalar operands (rs1/rs2 values) from the scalar pipeline and buffers them.
- Presents the head entry to the vector controller as vec_inst plus operands, and pops the entry when the vector datapath acknowledges completion.
- Filters non-vector opcodes and tracks in-flight vsetvl/vsetvli/vsetivli (CONF) instructions, so the scalar core can stall on the scalar rd writeback hazard.

Parameters:
- XLEN, 32, instruction and scalar operand width.
- DEPTH, 4, number of queue entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous queue clear (e.g. trap or branch mispredict).
- inst_valid  input  1  scalar side offers an instruction this cycle.
- inst_in  input  XLEN  raw 32-bit instruction.
- rs1_in  input  XLEN  scalar rs1 value captured with the instruction.
- rs2_in  input  XLEN  scalar rs2 value, or stride, captured with the instruction.
- inst_ready  output  1  queue can accept an entry this cycle.
- illegal_inst  output  1  one-cycle pulse when an offered instruction is not a vector opcode.
- vec_valid  output  1  head entry is valid.
- vec_inst  output  XLEN  head instruction, fed to the controller's vec_inst.
- rs1_out  output  XLEN  head rs1 value.
- rs2_out  output  XLEN  head rs2 value.
- vec_ack  input  1  vector datapath has finished the head entry; pop it.
- csr_pending  output  1  at least one CONF instruction is queued.
- occupancy  output  CNT_W  number of valid entries.

Behaviour:
- Reset (reset=0, asynchronous): all pointers, occupancy and CONF counter clear to 0. vec_valid=0, csr_pending=0, illegal_inst=0, inst_ready=1. vec_inst, rs1_out and rs2_out read 0.
- Vector opcode test: inst_in[6:0] ∈ {V_ARITH 7'h57, V_LOAD 7'h07, V_STORE 7'h27}.
- CONF test: opcode V_ARITH and inst_in[14:12]=CONF (3'b111).
- inst_ready = (occupancy < DEPTH). It is registered-state-derived only, with no combinational path from vec_ack.
- Push: occurs when inst_valid & inst_ready & vector opcode. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Non-vector opcode with inst_valid & inst_ready: not pushed; illegal_inst=1 in the next cycle for exactly one cycle.
- Pop: occurs when vec_ack & vec_valid; rd_ptr increments modulo DEPTH.
- vec_ack while empty: ignored, with no pointer or count change.
- Head outputs are first-word-fall-through, read combinationally from storage at rd_ptr.
  - Latency: a push into an empty queue gives vec_valid=1 in the next cycle.
  - When empty, vec_inst, rs1_out and rs2_out are forced to 0, so the controller decodes a NOP.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance. This includes occupancy==1, where the new entry becomes the head in the next cycle.
- Full (occupancy==DEPTH): inst_ready=0 and the offered instruction is not accepted, even if vec_ack pops in the same cycle.
- CONF counter: +1 on push of a CONF instruction, -1 on pop of a CONF head, unchanged when both happen. csr_pending = (conf_cnt != 0).
- flush: has priority over push and pop. It clears pointers, occupancy and conf_cnt in the next cycle; illegal_inst is not generated for that cycle.
- Reset asserted mid-operation: all state clears immediately and contents are discarded. Storage RAM need not be cleared, but outputs must read 0 via the empty forcing.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are determined from occupancy, not from pointer equality.

Test Plan:
- Reset then idle → occupancy=0, vec_valid=0, inst_ready=1, vec_inst=0, csr_pending=0.
- Push vadd.vv 0x022081D7 with rs1_in=0x11, rs2_in=0x22, then hold vec_ack=0 → next cycle vec_valid=1, vec_inst=0x022081D7, rs1_out=0x11, occupancy=1. Then vec_ack=1 for one cycle → vec_valid=0, vec_inst=0.
- Push 4 distinct V_ARITH/V_LOAD/V_STORE instructions back-to-back with DEPTH=4 → inst_ready=0 after the 4th. A 5th offer with vec_ack=1 in the same cycle is not accepted. Pops return entries in order, and 6 push/pop cycles exercise pointer wrap.
- Push vsetvli x5,x10,e32 (0x010572D7) then vadd → csr_pending=1 until the vsetvli pops, then 0 while vadd remains. Simultaneous push of a CONF and pop of a CONF keeps csr_pending=1.
- Offer 0x00000013 (addi) → not queued, occupancy unchanged, illegal_inst high for exactly one cycle.
- With 3 entries queued, assert flush together with inst_valid and vec_ack → next cycle occupancy=0, vec_valid=0, csr_pending=0. Also assert reset mid-stream → outputs immediately reset.

Source files
------------

// File: rtl/vec_inst_queue.sv
// vec_inst_queue: decoupling FIFO between the scalar issue stage and the vector controller.
// Latency: a push into an empty queue is visible at the head (vec_valid) one cycle later.
// Backpressure: inst_ready drops when all DEPTH entries are valid; it depends on registered state only.
//
// Ports:
//   clk, reset (async, active-low), flush (sync clear)
//   inst_valid/inst_in/rs1_in/rs2_in -> inst_ready : scalar-side offer
//   illegal_inst : one-cycle pulse after a non-vector opcode is offered and not queued
//   vec_valid/vec_inst/rs1_out/rs2_out <- vec_ack : first-word-fall-through head, popped on ack
//   csr_pending : a vset{i}vl{i} is still queued (scalar rd writeback hazard)
//   occupancy   : number of valid entries
module vec_inst_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inst_valid,
  input  logic [XLEN-1:0]  inst_in,
  input  logic [XLEN-1:0]  rs1_in,
  input  logic [XLEN-1:0]  rs2_in,
  output logic             inst_ready,
  output logic             illegal_inst,
  output logic             vec_valid,
  output logic [XLEN-1:0]  vec_inst,
  output logic [XLEN-1:0]  rs1_out,
  output logic [XLEN-1:0]  rs2_out,
  input  logic             vec_ack,
  output logic             csr_pending,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [6:0] V_ARITH = 7'h57;
  localparam logic [6:0] V_LOAD  = 7'h07;
  localparam logic [6:0] V_STORE = 7'h27;
  localparam logic [2:0] CONF    = 3'b111;

  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);
  localparam logic [PW-1:0]    L_PONE  = PW'(1);

  logic [XLEN-1:0]  r_inst_mem [DEPTH];
  logic [XLEN-1:0]  r_rs1_mem  [DEPTH];
  logic [XLEN-1:0]  r_rs2_mem  [DEPTH];

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] r_conf_cnt;
  logic             r_illegal;

  logic             w_ready;
  logic             w_valid;
  logic             w_is_vec;
  logic             w_is_conf;
  logic             w_head_conf;
  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_head_inst;

  assign w_ready  = (r_occ < L_DEPTH);
  assign w_valid  = (r_occ != '0);

  assign w_is_vec  = (inst_in[6:0] == V_ARITH) ||
                     (inst_in[6:0] == V_LOAD)  ||
                     (inst_in[6:0] == V_STORE);
  assign w_is_conf = (inst_in[6:0] == V_ARITH) && (inst_in[14:12] == CONF);

  assign w_head_inst = r_inst_mem[r_rd_ptr];
  assign w_head_conf = (w_head_inst[6:0] == V_ARITH) && (w_head_inst[14:12] == CONF);

  // Readiness is sampled before any same-cycle pop, so a full queue never
  // accepts an offer even when the head is being acknowledged.
  assign w_push = inst_valid & w_ready & w_is_vec & ~flush;
  assign w_pop  = vec_ack & w_valid & ~flush;

  // Storage carries no reset; stale contents are hidden by the empty forcing below.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= inst_in;
      r_rs1_mem[r_wr_ptr]  <= rs1_in;
      r_rs2_mem[r_wr_ptr]  <= rs2_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_conf_cnt <= '0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_conf_cnt <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= inst_valid & w_ready & ~w_is_vec;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + L_PONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + L_PONE;
      end

      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + L_ONE;
        2'b01:   r_occ <= r_occ - L_ONE;
        default: r_occ <= r_occ;
      endcase

      case ({w_push & w_is_conf, w_pop & w_head_conf})
        2'b10:   r_conf_cnt <= r_conf_cnt + L_ONE;
        2'b01:   r_conf_cnt <= r_conf_cnt - L_ONE;
        default: r_conf_cnt <= r_conf_cnt;
      endcase
    end
  end

  assign inst_ready   = w_ready;
  assign illegal_inst = r_illegal;
  assign vec_valid    = w_valid;
  assign occupancy    = r_occ;
  assign csr_pending  = (r_conf_cnt != '0);

  // An empty queue presents all-zero fields so the controller decodes a NOP.
  assign vec_inst = w_valid ? w_head_inst          : '0;
  assign rs1_out  = w_valid ? r_rs1_mem[r_rd_ptr]  : '0;
  assign rs2_out  = w_valid ? r_rs2_mem[r_rd_ptr]  : '0;

endmodule

// File: tb/tb_vec_inst_queue.sv
module tb_vec_inst_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             inst_valid;
  logic [XLEN-1:0]  inst_in;
  logic [XLEN-1:0]  rs1_in;
  logic [XLEN-1:0]  rs2_in;
  logic             inst_ready;
  logic             illegal_inst;
  logic             vec_valid;
  logic [XLEN-1:0]  vec_inst;
  logic [XLEN-1:0]  rs1_out;
  logic [XLEN-1:0]  rs2_out;
  logic             vec_ack;
  logic             csr_pending;
  logic [CNT_W-1:0] occupancy;

  vec_inst_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .inst_valid   (inst_valid),
    .inst_in      (inst_in),
    .rs1_in       (rs1_in),
    .rs2_in       (rs2_in),
    .inst_ready   (inst_ready),
    .illegal_inst (illegal_inst),
    .vec_valid    (vec_valid),
    .vec_inst     (vec_inst),
    .rs1_out      (rs1_out),
    .rs2_out      (rs2_out),
    .vec_ack      (vec_ack),
    .csr_pending  (csr_pending),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } ent_t;

  // Reference model: an ordered list of queued entries plus the pending illegal flag.
  ent_t q[$];
  bit   m_illegal;

  int checks = 0;
  int errors = 0;

  function automatic bit is_vec(input logic [31:0] ins);
    return (ins[6:0] == 7'h57) || (ins[6:0] == 7'h07) || (ins[6:0] == 7'h27);
  endfunction

  function automatic bit is_conf(input logic [31:0] ins);
    return (ins[6:0] == 7'h57) && (ins[14:12] == 3'b111);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t head;
    int   nconf;
    head  = '0;
    nconf = 0;
    if (q.size() != 0) head = q[0];
    foreach (q[i]) if (is_conf(q[i].inst)) nconf++;
    chk({tag, ".occupancy"},   32'(occupancy),     32'(q.size()));
    chk({tag, ".vec_valid"},   32'(vec_valid),     32'(q.size() != 0));
    chk({tag, ".inst_ready"},  32'(inst_ready),    32'(q.size() < DEPTH));
    chk({tag, ".vec_inst"},    vec_inst,           head.inst);
    chk({tag, ".rs1_out"},     rs1_out,            head.rs1);
    chk({tag, ".rs2_out"},     rs2_out,            head.rs2);
    chk({tag, ".csr_pending"}, 32'(csr_pending),   32'(nconf != 0));
    chk({tag, ".illegal"},     32'(illegal_inst),  32'(m_illegal));
  endtask

  // Drive one cycle of inputs, let the clock edge happen, advance the model, compare.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic ack, input logic fl);
    bit ready, push, pop, nill;
    inst_valid = v;
    inst_in    = ins;
    rs1_in     = r1;
    rs2_in     = r2;
    vec_ack    = ack;
    flush      = fl;
    ready = (q.size() < DEPTH);
    push  = v && ready && is_vec(ins);
    pop   = ack && (q.size() != 0);
    nill  = v && ready && !is_vec(ins);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      m_illegal = 1'b0;
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{inst: ins, rs1: r1, rs2: r2});
      m_illegal = nill;
    end
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0: r[6:0] = 7'h57;
      1: begin r[6:0] = 7'h57; r[14:12] = 3'b111; end
      2: r[6:0] = 7'h07;
      3: r[6:0] = 7'h27;
      4: r[6:0] = 7'h13;
      default: r[6:0] = 7'h33;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] seq_inst [4];
    logic [31:0] ri;

    reset      = 1'b0;
    flush      = 1'b0;
    inst_valid = 1'b0;
    inst_in    = '0;
    rs1_in     = '0;
    rs2_in     = '0;
    vec_ack    = 1'b0;
    m_illegal  = 1'b0;
    q.delete();

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;
    idle("idle");

    // Single vadd through the queue
    step("push_vadd", 1'b1, 32'h022081D7, 32'h11, 32'h22, 1'b0, 1'b0);
    idle("hold_vadd");
    step("pop_vadd", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to full, offer a fifth with a same-cycle pop, drain, then wrap
    seq_inst[0] = 32'h02208157;
    seq_inst[1] = 32'h02056007;
    seq_inst[2] = 32'h02056027;
    seq_inst[3] = 32'h022080D7;
    for (int i = 0; i < 4; i++)
      step("fill", 1'b1, seq_inst[i], 32'(100 + i), 32'(200 + i), 1'b0, 1'b0);
    step("full_offer_ack", 1'b1, 32'h0A000057, 32'h55, 32'h66, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("drain", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("wrap_prime", 1'b1, 32'h12345057, 32'h1, 32'h2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step("wrap_pushpop", 1'b1, 32'h00001007 | (32'(i) << 20), 32'(i), 32'(~i), 1'b1, 1'b0);
    step("wrap_last", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // CONF tracking
    step("push_vsetvli", 1'b1, 32'h010572D7, 32'h40, 32'h0, 1'b0, 1'b0);
    step("push_vadd2", 1'b1, 32'h022081D7, 32'h41, 32'h42, 1'b0, 1'b0);
    step("pop_vsetvli", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("pop_vadd2", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("conf_a", 1'b1, 32'h010572D7, 32'h7, 32'h0, 1'b0, 1'b0);
    step("conf_swap", 1'b1, 32'h0C0F7357, 32'h8, 32'h0, 1'b1, 1'b0);
    step("conf_drain", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Non-vector opcode
    step("addi", 1'b1, 32'h00000013, 32'h3, 32'h4, 1'b0, 1'b0);
    idle("addi_after");

    // Flush with competing push and pop
    for (int i = 0; i < 3; i++)
      step("pre_flush", 1'b1, 32'h010572D7 + (32'(i) << 15), 32'(i), 32'(i), 1'b0, 1'b0);
    step("flush", 1'b1, 32'h00000013, 32'h9, 32'h9, 1'b1, 1'b1);
    idle("post_flush");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      ri = rand_inst();
      step("rand", 1'($urandom_range(0, 3) != 0), ri, $urandom, $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset mid-stream: state clears without waiting for a clock edge
    for (int i = 0; i < 2; i++)
      step("pre_reset", 1'b1, 32'h010572D7, 32'h5, 32'h6, 1'b0, 1'b0);
    inst_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    m_illegal = 1'b0;
    check_all("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
